// File: rtl/ascensor_pkg.sv
// -----------------------------------------------------------------------------
// ascensor_pkg
// Shared definitions for the elevator door manager and the dispatch algorithm:
//   - puerta_e          : door FSM states
//   - PISO_*            : floor index constants (estado[1:0])
//   - B_*               : bit positions in the 10-bit request vector
//   - mascara_servida() : requests served when the door opens at a floor,
//                         taking the travel direction into account
//   - mascara_piso()    : every request belonging to a floor, any direction
// -----------------------------------------------------------------------------
package ascensor_pkg;

    localparam int NUM_BOTONES = 10;

    typedef enum logic [1:0] {
        CERRADA  = 2'd0,
        ABRIENDO = 2'd1,
        ABIERTA  = 2'd2,
        CERRANDO = 2'd3
    } puerta_e;

    localparam logic [1:0] PISO_1 = 2'd0;
    localparam logic [1:0] PISO_2 = 2'd1;
    localparam logic [1:0] PISO_3 = 2'd2;
    localparam logic [1:0] PISO_4 = 2'd3;

    // Hall calls
    localparam int B_P1_SUBE = 0;
    localparam int B_P2_BAJA = 1;
    localparam int B_P2_SUBE = 2;
    localparam int B_P3_BAJA = 3;
    localparam int B_P3_SUBE = 4;
    localparam int B_P4_BAJA = 5;
    // Cabin buttons
    localparam int B_CAB_P1  = 6;
    localparam int B_CAB_P2  = 7;
    localparam int B_CAB_P3  = 8;
    localparam int B_CAB_P4  = 9;

    // Requests cleared when the door is open at 'piso'. On the middle floors
    // only the hall call matching the current direction is served, so a
    // passenger waiting to go the other way keeps their request.
    function automatic logic [NUM_BOTONES-1:0] mascara_servida(
        input logic [1:0] piso,
        input logic       sube
    );
        logic [NUM_BOTONES-1:0] m;
        m = '0;
        case (piso)
            PISO_1: begin
                m[B_P1_SUBE] = 1'b1;
                m[B_CAB_P1]  = 1'b1;
            end
            PISO_2: begin
                m[B_CAB_P2]  = 1'b1;
                if (sube) m[B_P2_SUBE] = 1'b1;
                else      m[B_P2_BAJA] = 1'b1;
            end
            PISO_3: begin
                m[B_CAB_P3]  = 1'b1;
                if (sube) m[B_P3_SUBE] = 1'b1;
                else      m[B_P3_BAJA] = 1'b1;
            end
            default: begin
                m[B_P4_BAJA] = 1'b1;
                m[B_CAB_P4]  = 1'b1;
            end
        endcase
        return m;
    endfunction

    function automatic logic [NUM_BOTONES-1:0] mascara_piso(input logic [1:0] piso);
        return mascara_servida(piso, 1'b0) | mascara_servida(piso, 1'b1);
    endfunction

endpackage

// File: rtl/temporizador.sv
// -----------------------------------------------------------------------------
// temporizador
// Loadable down-counter that saturates at zero.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset (count -> 0)
//   carga_i  : load valor_i this cycle (has priority over counting)
//   valor_i  : load value
//   cero_o   : count is zero
// -----------------------------------------------------------------------------
module temporizador #(
    parameter int ANCHO = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             carga_i,
    input  logic [ANCHO-1:0] valor_i,
    output logic             cero_o
);

    logic [ANCHO-1:0] cuenta_q, cuenta_d;

    always_comb begin
        cuenta_d = cuenta_q;
        if (carga_i)                cuenta_d = valor_i;
        else if (cuenta_q != '0)    cuenta_d = cuenta_q - 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // values from before the edge, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cuenta_q <= '0;
        else        cuenta_q <= cuenta_d;
    end

    assign cero_o = (cuenta_q == '0);

endmodule

// File: rtl/gestor_puerta.sv
// -----------------------------------------------------------------------------
// gestor_puerta
// Elevator door manager: latches pending requests, opens the door when the
// cabin stops or a request exists at the idle floor, holds it open, closes it,
// and tells the dispatch algorithm to wait while the door is not closed.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   botones   : raw button presses (bit map in ascensor_pkg)
//   estado    : [3] moving, [2] up, [1:0] floor index
//   obstaculo : door-path obstruction, active-high
//   s         : latched pending requests
//   esperar   : door not closed (or stop just seen); algorithm must hold
//   abrir     : door motor open command
//   cerrar    : door motor close command
// -----------------------------------------------------------------------------
module gestor_puerta
    import ascensor_pkg::*;
#(
    parameter int T_ABRIR   = 4,
    parameter int T_ABIERTA = 16,
    parameter int T_CERRAR  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_BOTONES-1:0] botones,
    input  logic [3:0]             estado,
    input  logic                   obstaculo,
    output logic [NUM_BOTONES-1:0] s,
    output logic                   esperar,
    output logic                   abrir,
    output logic                   cerrar
);

    // The counter is loaded with T-1 on entry and the state exits when it
    // reads zero, so each phase lasts exactly T cycles.
    localparam logic [7:0] CARGA_ABRIR   = 8'(T_ABRIR - 1);
    localparam logic [7:0] CARGA_ABIERTA = 8'(T_ABIERTA - 1);
    localparam logic [7:0] CARGA_CERRAR  = 8'(T_CERRAR - 1);

    puerta_e                puerta_q, puerta_d;
    logic                   mov_q;
    logic [NUM_BOTONES-1:0] s_q, s_d;

    logic                   carga;
    logic [7:0]             valor;
    logic                   cero;

    logic [1:0]             piso;
    logic                   sube;
    logic                   moviendo;
    logic                   parada;
    logic [NUM_BOTONES-1:0] mask_servida;
    logic [NUM_BOTONES-1:0] mask_piso;
    logic [NUM_BOTONES-1:0] mask_borrado;

    assign piso         = estado[1:0];
    assign sube         = estado[2];
    assign moviendo     = estado[3];
    assign parada       = mov_q & ~moviendo;
    assign mask_servida = mascara_servida(piso, sube);
    assign mask_piso    = mascara_piso(piso);

    temporizador #(.ANCHO(8)) u_temporizador (
        .clk     (clk),
        .rst_n   (rst_n),
        .carga_i (carga),
        .valor_i (valor),
        .cero_o  (cero)
    );

    // NOTE: every signal driven here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        puerta_d = puerta_q;
        carga    = 1'b0;
        valor    = '0;
        case (puerta_q)
            CERRADA: begin
                // Stop events only matter here; in other states they are ignored.
                if (parada || (!moviendo && |((s_q | botones) & mask_piso))) begin
                    puerta_d = ABRIENDO;
                    carga    = 1'b1;
                    valor    = CARGA_ABRIR;
                end
            end
            ABRIENDO: begin
                if (cero) begin
                    puerta_d = ABIERTA;
                    carga    = 1'b1;
                    valor    = CARGA_ABIERTA;
                end
            end
            ABIERTA: begin
                // A new press at this floor or an obstruction restarts the hold
                // time, even on what would have been the last open cycle.
                if (obstaculo || |(botones & mask_servida)) begin
                    carga = 1'b1;
                    valor = CARGA_ABIERTA;
                end else if (cero) begin
                    puerta_d = CERRANDO;
                    carga    = 1'b1;
                    valor    = CARGA_CERRAR;
                end
            end
            CERRANDO: begin
                if (obstaculo) begin
                    puerta_d = ABRIENDO;
                    carga    = 1'b1;
                    valor    = CARGA_ABRIR;
                end else if (cero) begin
                    puerta_d = CERRADA;
                    carga    = 1'b1;
                    valor    = '0;
                end
            end
            default: begin
                puerta_d = CERRADA;
            end
        endcase
    end

    // Clear beats set: a press arriving while its floor is being served is
    // absorbed and never shows up in s.
    assign mask_borrado = (puerta_q == ABIERTA) ? mask_servida : '0;
    assign s_d          = (s_q | botones) & ~mask_borrado;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            puerta_q <= CERRADA;
            mov_q    <= 1'b0;
            s_q      <= '0;
        end else begin
            puerta_q <= puerta_d;
            mov_q    <= moviendo;
            s_q      <= s_d;
        end
    end

    assign s       = s_q;
    assign esperar = (puerta_q != CERRADA) | parada;
    assign abrir   = (puerta_q == ABRIENDO);
    assign cerrar  = (puerta_q == CERRANDO);

endmodule
